datapath_mux_pipe: RTL

Parametrised, pipelined N-way datapath operand selector with valid/ready flow control. Generalises the fixed 2–5 way combinational datapath muxes (operand B, ALU-out and memory-data selects) into one configurable block. Adds a registered output, a 2-entry skid buffer, a constant-fill path for unused select codes and a transfer counter. Sits between the register file / shifter outputs and the ALU or memory-data inputs, so the control unit can stall the datapath without losing a selected operand.

---
 rtl/dmux_pkg.sv | 41 ++++
 rtl/datapath_mux_pipe_if.sv | 39 +++
 rtl/dmux_skid2.sv | 76 +++++++
 rtl/datapath_mux_pipe.sv | 69 ++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared types and the select-resolution helper for datapath_mux_pipe.
package dmux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    localparam logic [31:0] DEFAULT_CONST_VAL = 32'd5;

    // Upper bounds the helper can handle: WIDTH <= 64, NUM_IN*WIDTH <= 1024.
    localparam int unsigned DMUX_MAX_W   = 64;
    localparam int unsigned DMUX_MAX_BUS = 1024;
    localparam int unsigned DMUX_BUS_IW  = 10;

    function automatic logic [DMUX_MAX_W-1:0] dmux_select(
        input logic [DMUX_MAX_BUS-1:0] bus,
        input int unsigned             sel,
        input int unsigned             num_in,
        input int unsigned             width,
        input logic [DMUX_MAX_W-1:0]   const_val
    );
        logic [DMUX_MAX_W-1:0]  r;
        logic [DMUX_BUS_IW-1:0] idx;
        r   = '0;
        idx = '0;
        if (sel >= num_in) begin
            r = const_val;
        end else begin
            for (int unsigned b = 0; b < DMUX_MAX_W; b++) begin
                if (b < width) begin
                    idx         = DMUX_BUS_IW'(sel * width + b);
                    r[b[5:0]]   = bus[idx];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/datapath_mux_pipe_if.sv
// Handshake/data bundle for datapath_mux_pipe; sel_err exists only with DMUX_SELERR_EN.
interface datapath_mux_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_IN  = 4,
    parameter int SEL_W   = 2,
    parameter int COUNT_W = 16
);
    // Both sides: a beat transfers on a rising clk edge where valid && ready;
    // a producer holds its payload stable while valid && !ready.
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] data_in;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        data_out;
    logic [SEL_W-1:0]        sel_out;
    logic                    out_valid;
    logic                    out_ready;
    logic [COUNT_W-1:0]      xfer_cnt;
`ifdef DMUX_SELERR_EN
    logic                    sel_err;
`endif

    modport master (
        output sel, data_in, in_valid, out_ready,
        input  in_ready, data_out, sel_out, out_valid, xfer_cnt
`ifdef DMUX_SELERR_EN
        , sel_err
`endif
    );

    modport slave (
        input  sel, data_in, in_valid, out_ready,
        output in_ready, data_out, sel_out, out_valid, xfer_cnt
`ifdef DMUX_SELERR_EN
        , sel_err
`endif
    );

endinterface

// File: rtl/dmux_skid2.sv
// Two-entry FIFO skid buffer with registered ready/valid; state exposed for debug.
module dmux_skid2
    import dmux_pkg::*;
#(
    parameter int PW = 34
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [PW-1:0] push_data,
    output logic          pop_valid,
    input  logic          pop_ready,
    output logic [PW-1:0] pop_data,
    output buf_state_e    state
);

    logic [PW-1:0] tail_q;
    logic          push;
    logic          pop;

    assign push = push_valid && push_ready;
    assign pop  = pop_valid && pop_ready;

    // Ready/valid are registered from the next state so neither output
    // ever depends combinationally on the opposite side's handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            pop_data   <= '0;
            tail_q     <= '0;
            pop_valid  <= 1'b0;
            push_ready <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        pop_data   <= push_data;
                        state      <= ONE;
                        pop_valid  <= 1'b1;
                    end
                    push_ready <= 1'b1;
                end
                ONE: begin
                    if (push && pop) begin
                        pop_data   <= push_data;
                        push_ready <= 1'b1;
                    end else if (push) begin
                        tail_q     <= push_data;
                        state      <= TWO;
                        push_ready <= 1'b0;
                    end else if (pop) begin
                        state      <= EMPTY;
                        pop_valid  <= 1'b0;
                        push_ready <= 1'b1;
                    end else begin
                        push_ready <= 1'b1;
                    end
                end
                TWO: begin
                    if (pop) begin
                        pop_data   <= tail_q;
                        state      <= ONE;
                        push_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    pop_valid  <= 1'b0;
                    push_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/datapath_mux_pipe.sv
// N-way operand selector with 2-entry skid output and transfer counter.
// Optional DMUX_SELERR_EN adds a per-entry out-of-range select flag (sel_err).
module datapath_mux_pipe
    import dmux_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               NUM_IN    = 4,
    parameter int               SEL_W     = 2,
    parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(DEFAULT_CONST_VAL),
    parameter int               COUNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    datapath_mux_pipe_if.slave   bus,
    output buf_state_e           state_dbg
);

`ifdef DMUX_SELERR_EN
    localparam int PW = WIDTH + SEL_W + 1;
`else
    localparam int PW = WIDTH + SEL_W;
`endif

    logic [DMUX_MAX_BUS-1:0] bus_ext;
    logic [DMUX_MAX_W-1:0]   sel_wide;
    logic [WIDTH-1:0]        sel_val;
    logic [PW-1:0]           push_data;
    logic [PW-1:0]           pop_data;
    logic [COUNT_W-1:0]      cnt_q;

    assign bus_ext  = DMUX_MAX_BUS'(bus.data_in);
    assign sel_wide = dmux_select(bus_ext, 32'(bus.sel), NUM_IN, WIDTH,
                                  DMUX_MAX_W'(CONST_VAL));
    assign sel_val  = sel_wide[WIDTH-1:0];

`ifdef DMUX_SELERR_EN
    logic sel_oor;
    assign sel_oor   = (32'(bus.sel) >= NUM_IN);
    assign push_data = {sel_oor, bus.sel, sel_val};
    assign {bus.sel_err, bus.sel_out, bus.data_out} = pop_data;
`else
    assign push_data = {bus.sel, sel_val};
    assign {bus.sel_out, bus.data_out} = pop_data;
`endif

    dmux_skid2 #(.PW(PW)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push_valid (bus.in_valid),
        .push_ready (bus.in_ready),
        .push_data  (push_data),
        .pop_valid  (bus.out_valid),
        .pop_ready  (bus.out_ready),
        .pop_data   (pop_data),
        .state      (state_dbg)
    );

    // Counts completed output handshakes; wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            cnt_q <= cnt_q + COUNT_W'(1);
        end
    end

    assign bus.xfer_cnt = cnt_q;

endmodule
